imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory. Receives a program as a byte stream over a valid/ready handshake (from a UART receiver or testbench), assembles 32-bit words big-endian, and drives the memory's synchronous write port at sequential addresses from 0.
- Holds the CPU while a load is in progress. Replaces the $readmemh initial load for boards without a simulator loader.

---
 rtl/imem_loader_if.sv | 64 ++++++
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//
// Bundles everything the instruction-memory loader exchanges with the outside
// world, apart from clock and reset:
//   - load control     : start (in), cpu_hold / done / error / words_loaded (out)
//   - byte stream      : in_valid / in_byte (in), in_ready (out)
//   - memory write port: wr_en / wr_addr / wr_data (out)
//
// Modports:
//   slave  - the loader itself (consumes the stream, drives the write port)
//   master - the host side (UART receiver, boot controller or testbench)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int addWidth  = 6,
   parameter int dataWidth = 32
);

   // Load control and status
   logic                  start;
   logic                  cpu_hold;
   logic                  done;
   logic                  error;
   logic [addWidth:0]     words_loaded;

   // Byte stream (valid/ready)
   logic                  in_valid;
   logic [7:0]            in_byte;
   logic                  in_ready;

   // Instruction memory synchronous write port
   logic                  wr_en;
   logic [addWidth-1:0]   wr_addr;
   logic [dataWidth-1:0]  wr_data;

   modport slave (
      input  start,
      input  in_valid,
      input  in_byte,
      output in_ready,
      output wr_en,
      output wr_addr,
      output wr_data,
      output cpu_hold,
      output done,
      output error,
      output words_loaded
   );

   modport master (
      output start,
      output in_valid,
      output in_byte,
      input  in_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  cpu_hold,
      input  done,
      input  error,
      input  words_loaded
   );

endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write-side counterpart of the instruction memory. A program arrives as a
// byte stream: one header byte H (word count N = H + 1) followed by 4*N data
// bytes. Bytes are assembled big-endian into 32-bit words, and each word is
// written to the memory at sequential addresses starting from 0. The CPU is
// held while a load is in progress or after a rejected header.
//
// Ports:
//   clk     - system clock, all state changes on the rising edge
//   reset   - asynchronous, active-high; abandons any load in progress
//   ldr_if  - imem_loader_if.slave:
//               start        one-cycle pulse, honoured in IDLE / DONE / ERROR
//               in_valid     in_byte holds a valid byte
//               in_byte      stream byte
//               in_ready     loader accepts a byte this cycle
//               wr_en        one-cycle memory write strobe
//               wr_addr      word address of the write
//               wr_data      word being written
//               cpu_hold     CPU must stall while 1
//               done         load completed (level)
//               error        header rejected (level)
//               words_loaded words written so far in this load
//
// dataWidth must be 32: the byte counter assumes four bytes per word.
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int addWidth  = 6,
   parameter int dataWidth = 32
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.slave  ldr_if
);

   // Word counters need one extra bit so a full memory (2**addWidth words)
   // is representable without wrapping.
   localparam int CntW = addWidth + 1;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      RECV,
      WRITE,
      DONE,
      ERROR
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                 state_q,     state_d;
   logic                   start_q;
   logic [1:0]             byte_cnt_q,  byte_cnt_d;
   // Only the first three bytes of a word need storing; the fourth is taken
   // straight from the stream when the word is handed to the write port.
   logic [dataWidth-9:0]   asm_q,       asm_d;
   logic [CntW-1:0]        n_words_q,   n_words_d;
   logic [CntW-1:0]        words_q,     words_d;
   logic [addWidth-1:0]    wr_addr_q,   wr_addr_d;
   logic [dataWidth-1:0]   wr_data_q,   wr_data_d;

   logic                   start_edge;
   logic                   in_ready;
   logic                   xfer;
   logic                   hdr_too_big;

   // start acts on its rising edge only, so a start held high across the end
   // of a load does not immediately trigger another one.
   assign start_edge = ldr_if.start & ~start_q;

   assign in_ready = (state_q == HDR) || (state_q == RECV);
   assign xfer     = ldr_if.in_valid & in_ready;

   // A header byte can only overflow the memory when the address space is
   // smaller than what one byte can describe.
   generate
      if (addWidth < 8) begin : g_hdr_check
         assign hdr_too_big = (int'(ldr_if.in_byte) >= (1 << addWidth));
      end else begin : g_no_hdr_check
         assign hdr_too_big = 1'b0;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: every register here is assigned with <= so all of them update from
   // the same pre-edge values; blocking = would let later lines see new values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         n_words_q  <= '0;
         words_q    <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         start_q    <= ldr_if.start;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         n_words_q  <= n_words_d;
         words_q    <= words_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every _d signal gets its hold value first, so no path through the
   // case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      n_words_d  = n_words_q;
      words_d    = words_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      unique case (state_q)
         IDLE, DONE, ERROR: begin
            if (start_edge) begin
               state_d    = HDR;
               words_d    = '0;
               byte_cnt_d = '0;
            end
         end

         HDR: begin
            if (xfer) begin
               if (hdr_too_big) begin
                  state_d = ERROR;
               end else begin
                  // N = H + 1; truncation only happens for headers that the
                  // range check above has already rejected.
                  n_words_d = CntW'(ldr_if.in_byte) + CntW'(1);
                  state_d   = RECV;
               end
            end
         end

         RECV: begin
            if (xfer) begin
               if (byte_cnt_q == 2'd3) begin
                  // Fourth byte: word complete, present it during WRITE.
                  wr_data_d  = {asm_q, ldr_if.in_byte};
                  wr_addr_d  = words_q[addWidth-1:0];
                  byte_cnt_d = '0;
                  state_d    = WRITE;
               end else begin
                  asm_d      = {asm_q[dataWidth-17:0], ldr_if.in_byte};
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end

         WRITE: begin
            words_d = words_q + CntW'(1);
            state_d = ((words_q + CntW'(1)) == n_words_q) ? DONE : RECV;
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign ldr_if.in_ready     = in_ready;
   assign ldr_if.wr_en        = (state_q == WRITE);
   assign ldr_if.wr_addr      = wr_addr_q;
   assign ldr_if.wr_data      = wr_data_q;
   assign ldr_if.cpu_hold     = (state_q == HDR)  || (state_q == RECV) ||
                                (state_q == WRITE) || (state_q == ERROR);
   assign ldr_if.done         = (state_q == DONE);
   assign ldr_if.error        = (state_q == ERROR);
   assign ldr_if.words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Drives programs into imem_loader over the byte stream and compares every
// memory write and the final status against a reference built directly from
// the stream: word k = {byte 4k, 4k+1, 4k+2, 4k+3} written at address k, one
// cycle after its fourth byte is accepted.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int AW = 6;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   imem_loader_if #(.addWidth(AW), .dataWidth(DW)) bus ();

   imem_loader #(.addWidth(AW), .dataWidth(DW)) dut (
      .clk    (clk),
      .reset  (reset),
      .ldr_if (bus)
   );

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Write monitor: records every strobe with the cycle it was seen in.
   // ---------------------------------------------------------------------------
   logic [AW-1:0] got_addr[$];
   logic [DW-1:0] got_data[$];
   int unsigned   got_cyc[$];

   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         got_addr.push_back(bus.wr_addr);
         got_data.push_back(bus.wr_data);
         got_cyc.push_back(cyc);
         check("in_ready_during_write", 64'(bus.in_ready), 64'd0);
      end
   end

   task automatic clear_mon();
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus helpers. All tasks start and end 1 time unit after a rising edge.
   // ---------------------------------------------------------------------------
   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Optionally idles for some cycles, then offers one byte until it is taken.
   // hs returns the cycle number in which the handshake was seen.
   task automatic send_byte(input logic [7:0] b, input int bubbles, input bit chk_gap,
                            output int unsigned hs);
      int waited;
      bit taken;
      waited = 0;
      taken  = 1'b0;
      hs     = 0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < bubbles; i++) begin
         @(negedge clk);
         if (chk_gap) check("gap_in_ready", 64'(bus.in_ready), 64'd1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_byte  = b;
      while (!taken && waited <= 20) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            hs    = cyc;
            taken = 1'b1;
         end else begin
            waited++;
         end
         @(posedge clk); #1;
      end
      if (!taken) check("handshake_timeout", 64'(waited), 64'd0);
   endtask

   task automatic chk_reset_outputs();
      check("rst_in_ready",     64'(bus.in_ready),     64'd0);
      check("rst_wr_en",        64'(bus.wr_en),        64'd0);
      check("rst_cpu_hold",     64'(bus.cpu_hold),     64'd0);
      check("rst_done",         64'(bus.done),         64'd0);
      check("rst_error",        64'(bus.error),        64'd0);
      check("rst_wr_addr",      64'(bus.wr_addr),      64'd0);
      check("rst_wr_data",      64'(bus.wr_data),      64'd0);
      check("rst_words_loaded", 64'(bus.words_loaded), 64'd0);
   endtask

   // Full load: start, header h, then prog (4*(h+1) bytes). start is held high
   // while bytes st_from..st_to are being sent, which must have no effect.
   task automatic run_load(input logic [7:0] h, input logic [7:0] prog[$],
                           input int gap_idx, input int gap_len, input bit rnd_bub,
                           input int st_from, input int st_to);
      int unsigned hs;
      int unsigned prev_hs;
      int unsigned exp_cyc[$];
      int          n;
      int          bub;
      int          k;
      logic [DW-1:0] exp_word;

      n       = int'(h) + 1;
      prev_hs = 0;
      clear_mon();
      pulse_start();
      send_byte(h, 0, 1'b0, hs);
      for (int i = 0; i < prog.size(); i++) begin
         bub = 0;
         if (i == gap_idx) bub = gap_len;
         else if (rnd_bub && $urandom_range(0, 3) == 0) bub = int'($urandom_range(1, 3));
         bus.start = (i >= st_from) && (i <= st_to);
         send_byte(prog[i], bub, (i == gap_idx), hs);
         // A byte offered during WRITE must be taken in the cycle right after it.
         if ((i % 4 == 0) && (i > 0) && (bub == 0))
            check("accept_after_write", 64'(hs), 64'(prev_hs + 2));
         if (i % 4 == 3) exp_cyc.push_back(hs + 1);
         prev_hs = hs;
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;

      k = 0;
      while (bus.done !== 1'b1 && bus.error !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("load_finished", 64'(k < 20), 64'd1);
      @(posedge clk); #1;

      check("end_done",         64'(bus.done),         64'd1);
      check("end_error",        64'(bus.error),        64'd0);
      check("end_cpu_hold",     64'(bus.cpu_hold),     64'd0);
      check("end_in_ready",     64'(bus.in_ready),     64'd0);
      check("end_words_loaded", 64'(bus.words_loaded), 64'(n));
      check("write_count",      64'(got_addr.size()),  64'(n));
      for (int j = 0; j < n && j < got_addr.size(); j++) begin
         exp_word = {prog[4*j], prog[4*j+1], prog[4*j+2], prog[4*j+3]};
         check("write_addr",    64'(got_addr[j]), 64'(j));
         check("write_data",    64'(got_data[j]), 64'(exp_word));
         check("write_latency", 64'(got_cyc[j]),  64'(exp_cyc[j]));
      end
   endtask

   // Header beyond memory capacity: ERROR the next cycle, no writes, and
   // further stream bytes are refused.
   task automatic run_bad_header(input logic [7:0] h);
      int unsigned hs;
      clear_mon();
      pulse_start();
      send_byte(h, 0, 1'b0, hs);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("err_error",    64'(bus.error),    64'd1);
      check("err_cpu_hold", 64'(bus.cpu_hold), 64'd1);
      check("err_in_ready", 64'(bus.in_ready), 64'd0);
      check("err_done",     64'(bus.done),     64'd0);
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'hA5;
      repeat (4) @(negedge clk);
      check("err_sticky",   64'(bus.error),       64'd1);
      check("err_no_write", 64'(got_addr.size()), 64'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic rand_prog(input int n_words, output logic [7:0] prog[$]);
      prog.delete();
      for (int i = 0; i < 4 * n_words; i++) prog.push_back(8'($urandom_range(0, 255)));
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [7:0]  prog[$];
      logic [7:0]  h;
      int unsigned hs;

      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;
      #1;
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_cpu_hold", 64'(bus.cpu_hold), 64'd0);

      // Two-word program, back-to-back and then with a bubble inside word 0.
      prog = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
      run_load(8'h01, prog, -1, 0, 1'b0, -1, -1);
      run_load(8'h01, prog, 2, 3, 1'b0, -1, -1);

      // Whole memory: word k = k.
      prog.delete();
      for (int k = 0; k < 64; k++) begin
         prog.push_back(8'h00);
         prog.push_back(8'h00);
         prog.push_back(8'h00);
         prog.push_back(8'(k));
      end
      run_load(8'h3F, prog, -1, 0, 1'b0, -1, -1);

      // Oversized header, then recovery with a valid load.
      run_bad_header(8'h40);
      rand_prog(2, prog);
      run_load(8'h01, prog, -1, 0, 1'b1, -1, -1);

      // Reset in the middle of a 4-word load.
      clear_mon();
      pulse_start();
      send_byte(8'h03, 0, 1'b0, hs);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 0, 1'b0, hs);
      bus.in_valid = 1'b0;
      check("mid_words_loaded", 64'(bus.words_loaded), 64'd1);
      check("mid_write_count",  64'(got_addr.size()),  64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_outputs();
      @(posedge clk); #1;
      reset = 1'b0;
      rand_prog(1, prog);
      run_load(8'h00, prog, -1, 0, 1'b0, -1, -1);

      // start held high through RECV and a WRITE cycle must be ignored.
      rand_prog(3, prog);
      run_load(8'h02, prog, -1, 0, 1'b0, 2, 6);

      // Randomized programs and headers.
      for (int r = 0; r < 8; r++) begin
         if (r % 4 == 3) begin
            run_bad_header(8'($urandom_range(64, 255)));
         end else begin
            h = 8'($urandom_range(0, 20));
            rand_prog(int'(h) + 1, prog);
            run_load(h, prog, -1, 0, 1'b1, -1, -1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
